// File: rtl/mc_control_unit.sv
// Multicycle RV32 control unit: a seven-state FSM that sequences fetch, decode,
// execute, branch, memory and write-back, and drives the datapath strobes and ALU select.
module mc_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_source,
  output logic       pc_write,
  output logic       ir_write,
  output logic       alu_out_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       is_halted
);

  localparam logic [3:0] FUNC_ADD  = 4'd0;
  localparam logic [3:0] FUNC_SUB  = 4'd1;
  localparam logic [3:0] FUNC_AND  = 4'd2;
  localparam logic [3:0] FUNC_OR   = 4'd3;
  localparam logic [3:0] FUNC_XOR  = 4'd4;
  localparam logic [3:0] FUNC_LRS  = 4'd5;
  localparam logic [3:0] FUNC_ARS  = 4'd6;
  localparam logic [3:0] FUNC_ZERO = 4'd7;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_BR, S_MEM, S_WB, S_HALT
  } state_e;

  state_e state_q, state_d;

  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_ecall, is_exec;
  logic [3:0] arith_op;

  assign is_r      = (opcode == 7'b0110011);
  assign is_i      = (opcode == 7'b0010011);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_branch = (opcode == 7'b1100011);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign is_ecall  = (opcode == 7'b1110011);
  assign is_exec   = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr;

  // SUB only exists for register-register ops; immediates reuse bit 30 as data.
  always_comb begin
    arith_op = FUNC_ZERO;
    case (funct3)
      3'b000:  arith_op = (is_r && funct7_5) ? FUNC_SUB : FUNC_ADD;
      3'b100:  arith_op = FUNC_XOR;
      3'b110:  arith_op = FUNC_OR;
      3'b111:  arith_op = FUNC_AND;
      3'b101:  arith_op = funct7_5 ? FUNC_ARS : FUNC_LRS;
      default: arith_op = FUNC_ZERO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:   if (mem_ready) state_d = S_ID;
      S_ID:   state_d = is_exec ? S_EX : (is_ecall ? S_HALT : S_WB);
      S_EX: begin
        if (is_r || is_i)             state_d = S_WB;
        else if (is_load || is_store) state_d = S_MEM;
        else if (is_branch)           state_d = alu_bcond ? S_BR : S_IF;
        else                          state_d = S_IF;
      end
      S_BR:   state_d = S_IF;
      S_MEM:  if (mem_ready) state_d = is_load ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Outputs are forced quiet while reset is held, even though the state is already IF.
  always_comb begin
    alu_op        = FUNC_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_source     = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    alu_out_write = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    is_halted     = 1'b0;
    if (reset) begin
      case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        S_ID: begin
          alu_src_b     = 2'd2;
          alu_out_write = 1'b1;
        end
        S_EX: begin
          if (is_r || is_i) begin
            alu_src_a     = 1'b1;
            alu_src_b     = is_r ? 2'd0 : 2'd1;
            alu_op        = arith_op;
            alu_out_write = 1'b1;
          end else if (is_load || is_store) begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'd1;
            alu_out_write = 1'b1;
          end else if (is_branch) begin
            alu_src_a = 1'b1;
            alu_op    = FUNC_SUB;
            pc_write  = ~alu_bcond;
            pc_source = ~alu_bcond;
          end else if (is_jal || is_jalr) begin
            reg_write = 1'b1;
            alu_src_a = is_jalr;
            alu_src_b = 2'd1;
            pc_write  = 1'b1;
          end
        end
        S_BR: begin
          alu_src_b = 2'd1;
          pc_write  = 1'b1;
        end
        S_MEM: begin
          i_or_d = 1'b1;
          if (is_load) begin
            mem_read = 1'b1;
          end else if (is_store) begin
            mem_write = 1'b1;
            if (mem_ready) begin
              alu_src_b = 2'd2;
              pc_write  = 1'b1;
            end
          end
        end
        S_WB: begin
          reg_write  = is_r | is_i | is_load;
          mem_to_reg = is_load;
          alu_src_b  = 2'd2;
          pc_write   = 1'b1;
        end
        S_HALT: is_halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed instruction table, random
// instruction stream against an instruction-level timeline model, and reset/halt sequences.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       alu_bcond;
  logic       mem_ready;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_source, pc_write, ir_write, alu_out_write, mem_read, mem_write;
  logic       i_or_d, reg_write, mem_to_reg, is_halted;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .alu_bcond(alu_bcond), .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_write(pc_write), .ir_write(ir_write),
    .alu_out_write(alu_out_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .is_halted(is_halted)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_AND = 4'd2, F_OR = 4'd3;
  localparam logic [3:0] F_XOR = 4'd4, F_LRS = 4'd5, F_ARS = 4'd6, F_ZERO = 4'd7;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_ECALL = 7'b1110011, OP_LUI = 7'b0110111;

  localparam logic [8:0] B_PCW = 9'h100, B_IRW = 9'h080, B_AOW = 9'h040, B_MRD = 9'h020;
  localparam logic [8:0] B_MWR = 9'h010, B_IOD = 9'h008, B_RGW = 9'h004, B_M2R = 9'h002;
  localparam logic [8:0] B_HLT = 9'h001;

  typedef struct {
    logic       mr;
    logic       bc;
    logic [3:0] op;
    logic       sa;
    logic [1:0] sb;
    logic       ps;
    logic       care_alu;
    logic       care_ps;
    logic [8:0] stb;
  } cyc_t;

  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7;
    logic       bc;
    int         if_stall;
    int         mem_stall;
    int         cycles;
    string      name;
  } vec_t;

  cyc_t sched[$];
  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic logic rbit();
    return $urandom_range(0, 1) != 0;
  endfunction

  function automatic cyc_t mk(logic mr, logic [8:0] stb, logic care_alu, logic [3:0] op,
                              logic sa, logic [1:0] sb, logic care_ps, logic ps);
    cyc_t c;
    c.mr = mr; c.bc = rbit(); c.stb = stb; c.care_alu = care_alu; c.op = op;
    c.sa = sa; c.sb = sb; c.care_ps = care_ps; c.ps = ps;
    return c;
  endfunction

  // Reference ALU function: base op by funct3, then the bit-30 variants.
  function automatic logic [3:0] ref_arith(logic r, logic [2:0] f3, logic f7);
    logic [3:0] base [8];
    logic [3:0] res;
    base = '{F_ADD, F_ZERO, F_ZERO, F_ZERO, F_XOR, F_LRS, F_OR, F_AND};
    res = base[f3];
    if (f3 == 3'd0 && r && f7) res = F_SUB;
    if (f3 == 3'd5 && f7)      res = F_ARS;
    return res;
  endfunction

  function automatic logic [8:0] stb_now();
    return {pc_write, ir_write, alu_out_write, mem_read, mem_write, i_or_d,
            reg_write, mem_to_reg, is_halted};
  endfunction

  // Instruction timeline: fetch (with stalls), decode, then the class-specific tail.
  task automatic build_schedule(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic bc, input int if_stall, input int mem_stall);
    cyc_t ex;
    logic r, i, ld, st, br, jl, jr;
    r = (opc == OP_R); i = (opc == OP_I); ld = (opc == OP_LD); st = (opc == OP_ST);
    br = (opc == OP_BR); jl = (opc == OP_JAL); jr = (opc == OP_JALR);
    sched.delete();
    for (int k = 0; k < if_stall; k++) sched.push_back(mk(1'b0, B_MRD, 0, F_ADD, 0, 0, 0, 0));
    sched.push_back(mk(1'b1, B_MRD | B_IRW, 0, F_ADD, 0, 0, 0, 0));
    sched.push_back(mk(rbit(), B_AOW, 1, F_ADD, 0, 2'd2, 0, 0));
    if (r || i) begin
      sched.push_back(mk(rbit(), B_AOW, 1, ref_arith(r, f3, f7), 1, r ? 2'd0 : 2'd1, 0, 0));
      sched.push_back(mk(rbit(), B_PCW | B_RGW, 1, F_ADD, 0, 2'd2, 1, 0));
    end else if (ld || st) begin
      sched.push_back(mk(rbit(), B_AOW, 1, F_ADD, 1, 2'd1, 0, 0));
      for (int k = 0; k < mem_stall; k++)
        sched.push_back(mk(1'b0, B_IOD | (ld ? B_MRD : B_MWR), 0, F_ADD, 0, 0, 0, 0));
      if (ld) begin
        sched.push_back(mk(1'b1, B_IOD | B_MRD, 0, F_ADD, 0, 0, 0, 0));
        sched.push_back(mk(rbit(), B_PCW | B_RGW | B_M2R, 1, F_ADD, 0, 2'd2, 1, 0));
      end else begin
        sched.push_back(mk(1'b1, B_IOD | B_MWR | B_PCW, 1, F_ADD, 0, 2'd2, 1, 0));
      end
    end else if (br) begin
      ex = mk(rbit(), bc ? 9'h0 : B_PCW, 1, F_SUB, 1, 2'd0, !bc, 1'b1);
      ex.bc = bc;
      sched.push_back(ex);
      if (bc) sched.push_back(mk(rbit(), B_PCW, 1, F_ADD, 0, 2'd1, 1, 0));
    end else if (jl || jr) begin
      sched.push_back(mk(rbit(), B_PCW | B_RGW, 1, F_ADD, jr, 2'd1, 1, 0));
    end else begin
      sched.push_back(mk(rbit(), B_PCW, 1, F_ADD, 0, 2'd2, 1, 0));
    end
  endtask

  task automatic check_output(input cyc_t e, input string name, input int n);
    logic [16:0] act, expv, mask;
    act  = {alu_op, alu_src_a, alu_src_b, pc_source, stb_now()};
    expv = {e.op, e.sa, e.sb, e.ps, e.stb};
    mask = {{7{e.care_alu}}, e.care_ps, 9'h1ff};
    checks++;
    if ((act & mask) !== (expv & mask)) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %05h want %05h (mask %05h)", name, n, act, expv, mask);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  // Runs one instruction until pc_write, checking each cycle and the total length.
  task automatic apply_stimulus(input vec_t v, input int exp_cycles);
    int n;
    bit done;
    int want;
    build_schedule(v.opc, v.f3, v.f7, v.bc, v.if_stall, v.mem_stall);
    want = (exp_cycles < 0) ? sched.size() : exp_cycles;
    n = 0;
    done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      opcode = v.opc; funct3 = v.f3; funct7_5 = v.f7;
      if (n < sched.size()) begin
        mem_ready = sched[n].mr; alu_bcond = sched[n].bc;
      end else begin
        mem_ready = 1'b1; alu_bcond = 1'b0;
      end
      #1;
      if (n < sched.size()) check_output(sched[n], v.name, n);
      if (pc_write) done = 1;
      n++;
    end
    check_val({v.name, "_cycles"}, done ? n : -1, want);
  endtask

  initial begin
    vec_t rv;
    logic [6:0] pool [10];
    pool = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, 7'b0010111, 7'b0001111};

    vecs.push_back('{OP_R,    3'b000, 1'b0, 1'b0, 0, 0, 4, "add"});
    vecs.push_back('{OP_R,    3'b000, 1'b1, 1'b0, 0, 0, 4, "sub"});
    vecs.push_back('{OP_I,    3'b000, 1'b1, 1'b0, 0, 0, 4, "addi_bit30"});
    vecs.push_back('{OP_I,    3'b100, 1'b0, 1'b0, 1, 0, 5, "xori_ifstall"});
    vecs.push_back('{OP_R,    3'b101, 1'b1, 1'b0, 0, 0, 4, "sra"});
    vecs.push_back('{OP_R,    3'b010, 1'b0, 1'b0, 0, 0, 4, "slt_zero"});
    vecs.push_back('{OP_LD,   3'b010, 1'b0, 1'b0, 0, 0, 5, "load"});
    vecs.push_back('{OP_LD,   3'b010, 1'b0, 1'b0, 0, 3, 8, "load_memstall3"});
    vecs.push_back('{OP_ST,   3'b010, 1'b0, 1'b0, 0, 0, 4, "store"});
    vecs.push_back('{OP_ST,   3'b010, 1'b0, 1'b0, 2, 2, 8, "store_stalls"});
    vecs.push_back('{OP_BR,   3'b000, 1'b0, 1'b0, 0, 0, 3, "branch_nt"});
    vecs.push_back('{OP_BR,   3'b000, 1'b0, 1'b1, 0, 0, 4, "branch_t"});
    vecs.push_back('{OP_JAL,  3'b000, 1'b0, 1'b0, 0, 0, 3, "jal"});
    vecs.push_back('{OP_JALR, 3'b000, 1'b0, 1'b0, 0, 0, 3, "jalr"});
    vecs.push_back('{OP_LUI,  3'b000, 1'b0, 1'b0, 0, 0, 3, "nop_lui"});

    reset = 1'b0; mem_ready = 1'b1; alu_bcond = 1'b0;
    opcode = OP_R; funct3 = 3'b000; funct7_5 = 1'b0;
    #2;
    check_val("reset_quiet", {pc_write, ir_write, alu_out_write, mem_write, reg_write, is_halted}, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;

    foreach (vecs[k]) apply_stimulus(vecs[k], vecs[k].cycles);

    for (int k = 0; k < 60; k++) begin
      rv.opc = pool[$urandom_range(0, 9)];
      rv.f3 = 3'($urandom_range(0, 7));
      rv.f7 = rbit();
      rv.bc = rbit();
      rv.if_stall = $urandom_range(0, 3);
      rv.mem_stall = $urandom_range(0, 3);
      rv.cycles = 0;
      rv.name = $sformatf("rand%0d", k);
      apply_stimulus(rv, -1);
    end

    // Reset in the middle of a SUB's execute cycle must suppress all writes.
    @(negedge clk);
    opcode = OP_R; funct3 = 3'b000; funct7_5 = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = rbit();
    @(negedge clk);
    #1;
    check_val("sub_ex_op", alu_op, F_SUB);
    #1 reset = 1'b0;
    #1 check_val("sub_reset_nowrite", {pc_write, reg_write, ir_write}, 0);
    repeat (2) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1 check_val("sub_reset_held", {pc_write, reg_write, ir_write}, 0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
    #1 check_val("sub_fresh_if", stb_now(), B_MRD);
    rv = '{OP_R, 3'b111, 1'b0, 1'b0, 0, 0, 4, "and_after_reset"};
    apply_stimulus(rv, 4);

    // ECALL halts; HALT ignores inputs and leaves only through asynchronous reset.
    @(negedge clk);
    opcode = OP_ECALL; mem_ready = 1'b1;
    #1 check_val("ecall_if", stb_now(), B_MRD | B_IRW);
    @(negedge clk);
    #1 check_val("ecall_id", stb_now(), B_AOW);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      mem_ready = rbit(); alu_bcond = rbit(); funct3 = 3'($urandom_range(0, 7));
      if (k > 0) opcode = 7'($urandom_range(0, 127));
      #1 check_val($sformatf("halt_hold%0d", k), stb_now(), B_HLT);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_val("halt_async_reset", stb_now() & ~B_MRD, 0);
    @(negedge clk);
    mem_ready = 1'b1; opcode = OP_R; funct3 = 3'b000; funct7_5 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 check_val("first_edge_if", stb_now(), B_MRD | B_IRW);
    @(negedge clk);
    #1 check_val("first_edge_id", stb_now(), B_AOW);
    #1 reset = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
    rv = '{OP_JAL, 3'b000, 1'b0, 1'b0, 1, 0, 4, "jal_after_halt"};
    apply_stimulus(rv, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
